// File: rtl/note_detector.sv
// note_detector: measures the high and low phase lengths of a square-wave
// note signal in clock cycles and reports each completed high+low pair.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   note     - square-wave input, same clock domain as clk
//   state    - current FSM state (SYNC=0000, MEAS_HIGH=0100, MEAS_LOW=0001)
//   high_len - length of the last complete high phase, in cycles
//   low_len  - length of the last complete low phase, in cycles
//   valid    - one-cycle pulse, high_len/low_len hold a new measurement
//   timeout  - one-cycle pulse, a phase exceeded 255 cycles and was dropped
//
// Build option: define NOTE_DETECTOR_SYNC_EN to put a 2-flop synchroniser
// in front of the edge detector (all responses move 2 cycles later).
module note_detector (
    input  logic       clk,
    input  logic       rst,
    input  logic       note,
    output logic [3:0] state,
    output logic [7:0] high_len,
    output logic [7:0] low_len,
    output logic       valid,
    output logic       timeout
);

    localparam int unsigned CNT_W = 8;

    localparam logic [3:0] SYNC      = 4'b0000;
    localparam logic [3:0] MEAS_HIGH = 4'b0100;
    localparam logic [3:0] MEAS_LOW  = 4'b0001;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(255);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic w_note;

`ifdef NOTE_DETECTOR_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchroniser ahead of the edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= note;
            r_sync2 <= r_sync1;
        end
    end

    assign w_note = r_sync2;
`else
    assign w_note = note;
`endif

    logic             r_note_q;
    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_tmp;
    logic [CNT_W-1:0] r_high_len;
    logic [CNT_W-1:0] r_low_len;
    logic             r_valid;
    logic             r_timeout;

    logic             w_rise;
    logic             w_fall;
    logic [3:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_hi_tmp_nxt;
    logic [CNT_W-1:0] w_high_len_nxt;
    logic [CNT_W-1:0] w_low_len_nxt;
    logic             w_valid_nxt;
    logic             w_timeout_nxt;

    assign w_rise = w_note & ~r_note_q;
    assign w_fall = ~w_note & r_note_q;

    // State and measurement registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_note_q   <= 1'b0;
            r_state    <= SYNC;
            r_cnt      <= '0;
            r_hi_tmp   <= '0;
            r_high_len <= '0;
            r_low_len  <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_note_q   <= w_note;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hi_tmp   <= w_hi_tmp_nxt;
            r_high_len <= w_high_len_nxt;
            r_low_len  <= w_low_len_nxt;
            r_valid    <= w_valid_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Next-state and next-output logic; an edge takes priority over the
    // saturation check, so a 255-cycle phase is still measured.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hi_tmp_nxt   = r_hi_tmp;
        w_high_len_nxt = r_high_len;
        w_low_len_nxt  = r_low_len;
        w_valid_nxt    = 1'b0;
        w_timeout_nxt  = 1'b0;

        case (r_state)
            SYNC: begin
                if (w_rise) begin
                    w_state_nxt = MEAS_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            MEAS_HIGH: begin
                if (w_fall) begin
                    w_hi_tmp_nxt = r_cnt;
                    w_cnt_nxt    = CNT_ONE;
                    w_state_nxt  = MEAS_LOW;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt   = SYNC;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            MEAS_LOW: begin
                if (w_rise) begin
                    w_high_len_nxt = r_hi_tmp;
                    w_low_len_nxt  = r_cnt;
                    w_valid_nxt    = 1'b1;
                    w_cnt_nxt      = CNT_ONE;
                    w_state_nxt    = MEAS_HIGH;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt   = SYNC;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = SYNC;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign state    = r_state;
    assign high_len = r_high_len;
    assign low_len  = r_low_len;
    assign valid    = r_valid;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector: directed, table-driven bench for note_detector plus
// hand-written sequences for periodic waves, timeout and the 255 boundary.
module tb_note_detector;

    localparam logic [3:0] S_SYNC = 4'b0000;
    localparam logic [3:0] S_MH   = 4'b0100;
    localparam logic [3:0] S_ML   = 4'b0001;

`ifdef NOTE_DETECTOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       note;
    logic [3:0] state;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic       valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rst;
        logic       note;
        logic [3:0] st;
        logic       vld;
        logic       tmo;
        logic [7:0] hi;
        logic [7:0] lo;
    } vec_t;

    vec_t tbl[$];

    note_detector dut (
        .clk      (clk),
        .rst      (rst),
        .note     (note),
        .state    (state),
        .high_len (high_len),
        .low_len  (low_len),
        .valid    (valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic n, input logic [3:0] st,
                       input logic v, input logic t, input logic [7:0] hi, input logic [7:0] lo);
        vec_t x;
        x.rst = r; x.note = n; x.st = st; x.vld = v; x.tmo = t; x.hi = hi; x.lo = lo;
        tbl.push_back(x);
    endtask

    task automatic do_reset();
        rst = 1'b1; note = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset, 3 high / 3 low / then high: valid must appear 6+LAT cycles
    // after the first rise cycle carrying 3/3.
    task automatic run_basic();
        int vat;
        logic [7:0] vhi, vlo;
        vat = -1; vhi = '0; vlo = '0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            note = (i < 3 || i >= 6) ? 1'b1 : 1'b0;
            tick();
            if (valid && vat < 0) begin
                vat = i; vhi = high_len; vlo = low_len;
            end
        end
        chk("basic_valid_cycle", 32'(vat), 32'(6 + LAT));
        chk("basic_lens", {16'h0, vhi, vlo}, {16'h0, 8'd3, 8'd3});
    endtask

    initial begin
        rst = 1'b1;
        note = 1'b0;

`ifndef NOTE_DETECTOR_SYNC_EN
        // rst note  state  vld tmo hi lo   (expected after the edge)
        add(1, 0, S_SYNC, 0, 0, 0, 0);
        add(1, 0, S_SYNC, 0, 0, 0, 0);
        add(0, 0, S_SYNC, 0, 0, 0, 0);
        add(0, 1, S_MH,   0, 0, 0, 0);   // rise, cnt=1
        add(0, 1, S_MH,   0, 0, 0, 0);
        add(0, 1, S_MH,   0, 0, 0, 0);
        add(0, 0, S_ML,   0, 0, 0, 0);   // fall, hi_tmp=3
        add(0, 0, S_ML,   0, 0, 0, 0);
        add(0, 0, S_ML,   0, 0, 0, 0);
        add(0, 1, S_MH,   1, 0, 3, 3);   // closing rise -> 3/3
        add(0, 1, S_MH,   0, 0, 3, 3);
        add(0, 0, S_ML,   0, 0, 3, 3);
        add(0, 1, S_MH,   1, 0, 2, 1);   // 1-cycle low glitch measured
        add(0, 0, S_ML,   0, 0, 2, 1);   // 1-cycle high glitch
        add(0, 1, S_MH,   1, 0, 1, 1);
        add(0, 0, S_ML,   0, 0, 1, 1);
        add(0, 0, S_ML,   0, 0, 1, 1);
        add(1, 0, S_SYNC, 0, 0, 0, 0);   // reset mid MEAS_LOW
        add(0, 0, S_SYNC, 0, 0, 0, 0);
        add(0, 1, S_MH,   0, 0, 0, 0);
        add(0, 1, S_MH,   0, 0, 0, 0);
        add(0, 0, S_ML,   0, 0, 0, 0);
        add(0, 0, S_ML,   0, 0, 0, 0);
        add(0, 0, S_ML,   0, 0, 0, 0);
        add(0, 0, S_ML,   0, 0, 0, 0);
        add(0, 0, S_ML,   0, 0, 0, 0);
        add(0, 0, S_ML,   0, 0, 0, 0);
        add(0, 1, S_MH,   1, 0, 2, 6);   // 2 high / 6 low
        add(0, 0, S_ML,   0, 0, 2, 6);
        // note high for 4 cycles spanning reset release; only the last
        // of them is outside reset and counts as a rise
        add(1, 1, S_SYNC, 0, 0, 0, 0);
        add(1, 1, S_SYNC, 0, 0, 0, 0);
        add(1, 1, S_SYNC, 0, 0, 0, 0);
        add(0, 1, S_MH,   0, 0, 0, 0);
        add(0, 0, S_ML,   0, 0, 0, 0);
        add(0, 1, S_MH,   1, 0, 1, 1);
        add(0, 0, S_ML,   0, 0, 1, 1);
        add(0, 1, S_MH,   1, 0, 1, 1);

        foreach (tbl[k]) begin
            rst  = tbl[k].rst;
            note = tbl[k].note;
            tick();
            checks++;
            if ({state, valid, timeout, high_len, low_len} !==
                {tbl[k].st, tbl[k].vld, tbl[k].tmo, tbl[k].hi, tbl[k].lo}) begin
                errors++;
                $display("FAIL vec%0d: got st=%b v=%b t=%b hi=%0d lo=%0d, expected st=%b v=%b t=%b hi=%0d lo=%0d",
                         k, state, valid, timeout, high_len, low_len,
                         tbl[k].st, tbl[k].vld, tbl[k].tmo, tbl[k].hi, tbl[k].lo);
            end
        end

        // Continuous 5 high / 2 low, 4 periods plus the closing rise
        begin
            int vt[$];
            int bad_len;
            bad_len = 0;
            do_reset();
            for (int t = 0; t < 29; t++) begin
                note = ((t % 7) < 5) ? 1'b1 : 1'b0;
                tick();
                if (valid) begin
                    vt.push_back(t);
                    if (high_len != 8'd5 || low_len != 8'd2) bad_len++;
                end
            end
            chk("period_valid_count", 32'(vt.size()), 32'd4);
            if (vt.size() == 4) begin
                chk("period_first_valid", 32'(vt[0]), 32'd7);
                for (int j = 1; j < 4; j++)
                    chk("period_spacing", 32'(vt[j] - vt[j-1]), 32'd7);
            end
            chk("period_lens", 32'(bad_len), 32'd0);
        end

        // Hold high: rise cycle was the last one above, 256 high total
        begin
            int early_tmo, any_vld;
            early_tmo = 0; any_vld = 0;
            for (int i = 2; i <= 256; i++) begin
                note = 1'b1;
                tick();
                if (valid) any_vld++;
                if (i < 256 && (timeout || state != S_MH)) early_tmo++;
            end
            chk("hold_no_early_timeout", 32'(early_tmo), 32'd0);
            chk("hold_timeout", 32'(timeout), 32'd1);
            chk("hold_state_sync", 32'(state), 32'(S_SYNC));
            chk("hold_lens_kept", {16'h0, high_len, low_len}, {16'h0, 8'd5, 8'd2});
            note = 1'b1;
            tick();
            if (valid) any_vld++;
            chk("timeout_one_cycle", 32'(timeout), 32'd0);
            chk("hold_no_valid", 32'(any_vld), 32'd0);
        end

        // Boundary: a 255-cycle high phase is measured, no timeout
        begin
            int tmo_seen;
            tmo_seen = 0;
            note = 1'b0;
            tick();
            for (int i = 0; i < 255; i++) begin
                note = 1'b1;
                tick();
                if (timeout) tmo_seen++;
            end
            note = 1'b0;
            tick();
            if (timeout) tmo_seen++;
            note = 1'b1;
            tick();
            chk("max_high_valid", 32'(valid), 32'd1);
            chk("max_high_lens", {16'h0, high_len, low_len}, {16'h0, 8'd255, 8'd1});
            chk("max_high_no_timeout", 32'(tmo_seen), 32'd0);
        end
`endif

        run_basic();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
